// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has per-cycle priority, DMA word bursts are
// sequenced internally with a starvation guard that forces periodic DMA beats.
module dmem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned LW           = $clog2(MAX_BURST) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  input  logic [2:0]      cpu_funct3,
  output logic            cpu_gnt,
  output logic            cpu_stall,
  output logic [XLEN-1:0] cpu_rdata,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [LW-1:0]   dma_len,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_busy,
  output logic            dma_done,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic [2:0]      mem_ctrl,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [XLEN-1:0] base;
  logic [LW-1:0]   len_q;
  logic            we_q;
  logic [LW-1:0]   beat;
  logic [SW-1:0]   starve;
  logic            done_q;

  logic            beat_ok;
  logic            force_beat;
  logic            last_beat;
  logic [LW-1:0]   len_clamped;

  assign len_clamped = (dma_len > LW'(MAX_BURST)) ? LW'(MAX_BURST) : dma_len;
  assign beat_ok     = (state == BURST) && (len_q != '0);
  assign force_beat  = (starve == SW'(STARVE_LIMIT));
  assign last_beat   = (beat == len_q - LW'(1));

  // Grants are gated by rst so nothing reaches the memory while reset is held.
  assign dma_gnt   = ~rst & beat_ok & (~cpu_req | force_beat);
  assign cpu_gnt   = ~rst & cpu_req & ~(beat_ok & force_beat);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign cpu_rdata = mem_rd;
  assign dma_rdata = mem_rd;
  assign dma_busy  = (state == BURST);
  assign dma_done  = done_q;

  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    mem_ctrl = '0;
    if (dma_gnt) begin
      mem_we   = we_q;
      mem_a    = base + (XLEN'(beat) << 2);
      mem_wd   = dma_wdata;
      mem_ctrl = 3'b010;
    end else if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_a    = cpu_addr;
      mem_wd   = cpu_wdata;
      mem_ctrl = cpu_funct3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base   <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      beat   <= '0;
      starve <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          starve <= '0;
          if (dma_req) begin
            base  <= dma_addr;
            len_q <= len_clamped;
            we_q  <= dma_we;
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          // A zero-length burst still spends one cycle in BURST and reports done.
          if (len_q == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (dma_gnt) begin
            starve <= '0;
            beat   <= beat + LW'(1);
            if (last_beat) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end else if (cpu_gnt) begin
            starve <= starve + SW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-addressed memory model plus a
// DMA beat scoreboard filled when bursts are requested.
module tb_dmem_arbiter;

  localparam int XLEN = 32;
  localparam int LW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req, cpu_we;
  logic [31:0]     cpu_addr, cpu_wdata;
  logic [2:0]      cpu_funct3;
  logic            cpu_gnt, cpu_stall;
  logic [31:0]     cpu_rdata;
  logic            dma_req, dma_we;
  logic [31:0]     dma_addr;
  logic [LW-1:0]   dma_len;
  logic [31:0]     dma_wdata;
  logic            dma_gnt;
  logic [31:0]     dma_rdata;
  logic            dma_busy, dma_done;
  logic            mem_we;
  logic [31:0]     mem_a, mem_wd;
  logic [2:0]      mem_ctrl;
  logic [31:0]     mem_rd = '0;

  dmem_arbiter #(.XLEN(32), .MAX_BURST(16), .STARVE_LIMIT(8), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t      exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = rb(a);
    h = {rb(a + 32'd1), rb(a)};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return {rb(a + 32'd3), rb(a + 32'd2), h};
    endcase
  endfunction

  // Combinational-read memory: read data settles at negedge, stores commit at posedge.
  always @(negedge clk) mem_rd = mread(mem_a, mem_ctrl);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a] = mem_wd[7:0];
      if (mem_ctrl[1:0] != 2'b00) mem[mem_a + 32'd1] = mem_wd[15:8];
      if (mem_ctrl[1:0] == 2'b10) begin
        mem[mem_a + 32'd2] = mem_wd[23:16];
        mem[mem_a + 32'd3] = mem_wd[31:24];
      end
    end
  end

  // Scoreboard: every DMA beat must match the oldest expected beat.
  always begin
    beat_t e;
    @(negedge clk);
    #1;
    if (dma_gnt) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dma_beat_unexpected: got beat at addr %h, required no beat", mem_a);
      end else begin
        e = exp_q.pop_front();
        if ({mem_a, mem_we, mem_ctrl, (e.we ? mem_wd : dma_rdata)} !== {e.addr, e.we, 3'b010, e.data}) begin
          n_fail++;
          $display("FAIL dma_beat: got a=%h we=%b ctrl=%b d=%h, required a=%h we=%b ctrl=010 d=%h",
                   mem_a, mem_we, mem_ctrl, (e.we ? mem_wd : dma_rdata), e.addr, e.we, e.data);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    dma_wdata = (exp_q.size() > 0) ? exp_q[0].data : '0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic start_burst(input logic we, input logic [31:0] addr, input logic [LW-1:0] len,
                             input logic [31:0] first);
    int unsigned n;
    dma_req  = 1'b1;
    dma_we   = we;
    dma_addr = addr;
    dma_len  = len;
    n = (len > 16) ? 16 : int'(len);
    for (int unsigned i = 0; i < n; i++)
      exp_q.push_back('{addr + 32'(i * 4), we, first + 32'(i)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1; cpu_funct3 = 3'b010;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_len = 5'd1; dma_wdata = '0;
    settle();
    n_checks++;
    if ({cpu_gnt, dma_gnt, mem_we, dma_busy, dma_done, cpu_stall} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000001",
               {cpu_gnt, dma_gnt, mem_we, dma_busy, dma_done, cpu_stall});
    end
    next();
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    settle();
    n_checks++;
    if ({dma_busy, dma_done, cpu_gnt, mem_we, mem_a, mem_wd, mem_ctrl} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b a=%h wd=%h ctrl=%b, required all 0",
               dma_busy, dma_done, mem_a, mem_wd, mem_ctrl);
    end
  endtask

  task automatic test_cpu();
    next();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_funct3 = 3'b010;
    settle();
    n_checks++;
    if ({cpu_gnt, cpu_stall, mem_we, mem_a, mem_wd, mem_ctrl} !== {2'b10, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010}) begin
      n_fail++;
      $display("FAIL cpu_store: got gnt=%b stall=%b we=%b a=%h wd=%h ctrl=%b, required 1 0 1 10 deadbeef 010",
               cpu_gnt, cpu_stall, mem_we, mem_a, mem_wd, mem_ctrl);
    end
    next();
    cpu_we = 1'b0; cpu_addr = 32'h13; cpu_funct3 = 3'b000;
    settle();
    n_checks++;
    if ({cpu_gnt, cpu_stall, cpu_rdata} !== {2'b10, 32'hFFFFFFDE}) begin
      n_fail++;
      $display("FAIL cpu_lb: got gnt=%b stall=%b rdata=%h, required 1 0 ffffffde", cpu_gnt, cpu_stall, cpu_rdata);
    end
    next();
    cpu_addr = 32'h12; cpu_funct3 = 3'b101;
    settle();
    n_checks++;
    if ({mem_ctrl, cpu_rdata} !== {3'b101, 32'h0000DEAD}) begin
      n_fail++;
      $display("FAIL cpu_lhu: got ctrl=%b rdata=%h, required 101 0000dead", mem_ctrl, cpu_rdata);
    end
    next();
    cpu_req = 1'b0;
  endtask

  task automatic test_dma_write();
    next();
    start_burst(1'b1, 32'h100, 5'd4, 32'd1);
    settle();
    n_checks++;
    if ({dma_gnt, dma_busy, dma_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL dma_accept: got gnt/busy/done=%b, required 000", {dma_gnt, dma_busy, dma_done});
    end
    for (int i = 0; i < 4; i++) begin
      next();
      dma_req = 1'b0;
      settle();
      n_checks++;
      if ({dma_gnt, dma_busy, dma_done} !== 3'b110) begin
        n_fail++;
        $display("FAIL dma_write_beat%0d: got gnt/busy/done=%b, required 110", i, {dma_gnt, dma_busy, dma_done});
      end
    end
    next();
    settle();
    n_checks++;
    if ({dma_gnt, dma_busy, dma_done} !== 3'b001) begin
      n_fail++;
      $display("FAIL dma_write_done: got gnt/busy/done=%b, required 001", {dma_gnt, dma_busy, dma_done});
    end
    next();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h108; cpu_funct3 = 3'b010;
    settle();
    n_checks++;
    if ({dma_done, cpu_rdata} !== {1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL dma_write_readback: got done=%b rdata=%h, required 0 00000003", dma_done, cpu_rdata);
    end
    next();
    cpu_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic b;
    next();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_funct3 = 3'b010;
    start_burst(1'b0, 32'h100, 5'd2, 32'd1);
    settle();
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL starve_accept: got cpu_gnt/dma_gnt=%b, required 10", {cpu_gnt, dma_gnt});
    end
    for (int k = 1; k <= 19; k++) begin
      next();
      dma_req = 1'b0;
      settle();
      b = (k == 9 || k == 18);
      n_checks++;
      if ({dma_gnt, cpu_gnt, cpu_stall, dma_busy, dma_done} !== {b, ~b, b, (k != 19), (k == 19)}) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: got gnt/cgnt/stall/busy/done=%b, required %b", k,
                 {dma_gnt, cpu_gnt, cpu_stall, dma_busy, dma_done}, {b, ~b, b, (k != 19), (k == 19)});
      end
    end
    next();
    cpu_req = 1'b0;
  endtask

  task automatic test_len_zero();
    next();
    start_burst(1'b0, 32'h400, 5'd0, 32'd0);
    settle();
    for (int k = 1; k <= 3; k++) begin
      next();
      dma_req = 1'b0;
      settle();
      n_checks++;
      if ({dma_gnt, dma_busy, dma_done} !== {1'b0, (k == 1), (k == 2)}) begin
        n_fail++;
        $display("FAIL len_zero_cycle%0d: got gnt/busy/done=%b, required %b", k,
                 {dma_gnt, dma_busy, dma_done}, {1'b0, (k == 1), (k == 2)});
      end
    end
  endtask

  task automatic test_wrap_and_clamp();
    int unsigned busy_cycles;
    next();
    start_burst(1'b1, 32'hFFFFFFF8, 5'd4, 32'hA0);
    for (int k = 0; k < 6; k++) begin
      next();
      dma_req = 1'b0;
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_funct3 = 3'b010;
    settle();
    n_checks++;
    if (cpu_rdata !== 32'hA2) begin
      n_fail++;
      $display("FAIL wrap_readback: got %h, required 000000a2", cpu_rdata);
    end
    next();
    cpu_req = 1'b0;
    // Oversized length: 16 beats over 0x100.., only the first four words hold data.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_len = 5'd31;
    for (int unsigned i = 0; i < 16; i++)
      exp_q.push_back('{32'h100 + 32'(i * 4), 1'b0, (i < 4) ? 32'(i + 1) : 32'h0});
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      next();
      dma_req = 1'b0;
      settle();
      if (dma_busy) busy_cycles++;
    end
    n_checks++;
    if ({busy_cycles, exp_q.size()} !== {32'd16, 32'd0}) begin
      n_fail++;
      $display("FAIL clamp_len: got busy cycles %0d pending %0d, required 16 and 0", busy_cycles, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    next();
    start_burst(1'b1, 32'h300, 5'd8, 32'h30);
    for (int k = 0; k < 2; k++) begin
      next();
      dma_req = 1'b0;
    end
    next();
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500;
    settle();
    n_checks++;
    if ({cpu_gnt, dma_gnt, mem_we, dma_busy, dma_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got cgnt/dgnt/we/busy/done=%b, required 00000",
               {cpu_gnt, dma_gnt, mem_we, dma_busy, dma_done});
    end
    exp_q.delete();
    next();
    rst = 1'b0; cpu_req = 1'b0;
    start_burst(1'b0, 32'h300, 5'd2, 32'h30);
    settle();
    n_checks++;
    if ({dma_gnt, dma_busy, dma_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: got gnt/busy/done=%b, required 000", {dma_gnt, dma_busy, dma_done});
    end
    next();
    dma_req = 1'b0;
    settle();
    n_checks++;
    if ({dma_gnt, dma_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_reaccept: got gnt/busy=%b, required 11", {dma_gnt, dma_busy});
    end
    next();
    next();
    next();
  endtask

  task automatic test_back_to_back();
    logic [2:0] want [8] = '{3'b000, 3'b110, 3'b110, 3'b001, 3'b110, 3'b110, 3'b001, 3'b000};
    next();
    start_burst(1'b0, 32'h100, 5'd2, 32'd1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next();
      if (c == 1) dma_addr = 32'h108;
      if (c == 6) dma_req = 1'b0;
      settle();
      if (c == 3) begin
        for (int unsigned i = 0; i < 2; i++)
          exp_q.push_back('{32'h108 + 32'(i * 4), 1'b0, 32'(i + 3)});
      end
      n_checks++;
      if ({dma_gnt, dma_busy, dma_done} !== want[c]) begin
        n_fail++;
        $display("FAIL back_to_back_cycle%0d: got gnt/busy/done=%b, required %b", c,
                 {dma_gnt, dma_busy, dma_done}, want[c]);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_drain: got %0d pending beats, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_cpu();
    test_dma_write();
    test_starvation();
    test_len_zero();
    test_wrap_and_clamp();
    test_reset_mid_burst();
    test_back_to_back();
    next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and burst sequencer placed in front of the byte-addressed data memory. It shares the single memory port between the CPU load/store stage and a DMA/loader engine. The CPU has per-cycle priority, and a starvation guard ensures DMA progress. DMA transfers are word bursts that the block sequences itself: it generates the per-beat address and forces word-width access control.

## Interface
- `XLEN`, 32: data/address width
- `MAX_BURST`, 16: maximum DMA burst length in words (power of two)
- `STARVE_LIMIT`, 8: consecutive denied DMA beat-cycles before a forced DMA beat (≥1)
- `LW`, `$clog2(MAX_BURST)+1`: derived width of `dma_len`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU access this cycle
- `cpu_we`  in  1  CPU store
- `cpu_addr`  in  XLEN  CPU byte address
- `cpu_wdata`  in  XLEN  CPU store data
- `cpu_funct3`  in  3  CPU load/store funct3
- `cpu_gnt`  out  1  CPU access performed this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rdata`  out  XLEN  load data, valid when `cpu_gnt`
- `dma_req`  in  1  start a burst (sampled in IDLE only)
- `dma_we`  in  1  burst direction: 1 = write, 0 = read
- `dma_addr`  in  XLEN  burst base byte address
- `dma_len`  in  LW  beat count, 0..MAX_BURST
- `dma_wdata`  in  XLEN  write data for the current beat
- `dma_gnt`  out  1  a DMA beat is performed this cycle
- `dma_rdata`  out  XLEN  read data, valid when `dma_gnt & ~dma_we_latched`
- `dma_busy`  out  1  state is BURST
- `dma_done`  out  1  one-cycle pulse when a burst finishes
- `mem_we`  out  1  memory write enable
- `mem_a`  out  XLEN  memory address
- `mem_wd`  out  XLEN  memory write data
- `mem_ctrl`  out  3  memory addressing control (funct3)
- `mem_rd`  in  XLEN  memory combinational read data

## Operation
- **Registered state.**
  - FSM `{IDLE, BURST}`.
  - Latched base address, length, and direction.
  - Beat counter (LW bits).
  - Starvation counter (`$clog2(STARVE_LIMIT)+1` bits).
- **IDLE.**
  - `cpu_gnt = cpu_req`.
  - If `dma_req`: latch `dma_addr`, `dma_len`, `dma_we`; clear the beat counter; go to BURST.
  - No DMA beat occurs in the accept cycle.
- **BURST, beat decision.**
  - `force = (starve_cnt == STARVE_LIMIT)`.
  - `dma_gnt = ~cpu_req | force`.
  - `cpu_gnt = cpu_req & ~force`.
  - Exactly one of `dma_gnt`/`cpu_gnt` is high when `cpu_req=1`.
- **Starvation counter.**
  - Increments on each BURST cycle with `cpu_gnt=1`.
  - Clears on any `dma_gnt`.
  - Clears in IDLE.
  - Never exceeds `STARVE_LIMIT`.
- **DMA beat.**
  - `mem_a = base + {beat, 2'b00}`, computed in XLEN bits and wrapping modulo 2^XLEN.
  - `mem_ctrl = 3'b010`.
  - `mem_we = dma_we_latched`.
  - `mem_wd = dma_wdata`.
  - `beat` increments.
- **Burst end.**
  - On the beat where `beat == len-1`: next state IDLE, and `dma_done` pulses in the following cycle.
  - `len == 0`: no beats; BURST lasts one cycle with `dma_gnt=0`, then IDLE with `dma_done` pulsing in the next cycle.
  - `len > MAX_BURST` is clamped to `MAX_BURST`.
- **CPU access.** `mem_a = cpu_addr`, `mem_we = cpu_we`, `mem_wd = cpu_wdata`, `mem_ctrl = cpu_funct3`.
- **No grant.** `mem_we = 0`; `mem_a`, `mem_wd`, `mem_ctrl` are 0.
- **Read data.** `cpu_rdata = mem_rd` and `dma_rdata = mem_rd` (unqualified; consumers qualify with their grant).
- **`dma_req` in BURST:** ignored. A new burst is accepted only in IDLE, earliest the cycle `dma_done` is high.
- **Reset.**
  - `rst` asserted at any time, including mid-burst: immediately returns to IDLE, clears all counters, `dma_done=0`, `dma_busy=0`.
  - All grants and `mem_we` are forced 0 while `rst=1`.
  - Beats already written stay in memory.

## Timing
- The CPU access completes in the request cycle when granted (zero added latency). Stores commit at the memory's next clock edge; loads are combinational.
- DMA burst of N beats with no CPU traffic:
  - accept cycle t;
  - beats at t+1..t+N;
  - `dma_done` at t+N+1;
  - `dma_busy` high t+1..t+N.
- With continuous `cpu_req`, the DMA gets one beat every `STARVE_LIMIT+1` cycles.
- All outputs except `dma_done`/`dma_busy` are combinational from state and inputs. `dma_done` and `dma_busy` are registered. No combinational path from `mem_rd` to any grant.

## Test plan
- **CPU-only traffic.** SW 0xDEADBEEF @0x10, then LB @0x13 → `cpu_gnt=1` both cycles, `cpu_stall=0`, load returns 0xFFFFFFDE.
- **DMA write burst, idle CPU.** base 0x100, len 4, data 1..4 → `dma_gnt` for 4 consecutive cycles, `mem_a` = 0x100/104/108/10C, `mem_ctrl=010`, `dma_done` one cycle after the last beat; a CPU LW @0x108 afterwards returns 3.
- **Starvation.** `cpu_req` held high, DMA read burst len 2, `STARVE_LIMIT=8` → DMA beats on cycles 9 and 18 after accept; `cpu_stall=1` exactly on those cycles.
- **Boundaries.**
  - len 0 → BURST for 1 cycle, no `dma_gnt`, `dma_done` pulses.
  - base 0xFFFFFFF8, len 4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- **Reset mid-burst.** Assert `rst` after beat 2 of 8 → `dma_busy=0` and no grants immediately; no `dma_done`. After release, a new `dma_req` is accepted in the first cycle.
- **Back-to-back bursts.** `dma_req` held high throughout → second burst accepted in the `dma_done` cycle; `dma_req` is ignored during BURST.
